// File: rtl/turn_pkg.sv
// Shared types and constants for the turn-input controller.
package turn_pkg;

  typedef enum logic [2:0] {
    POC   = 3'd0,
    WP    = 3'd1,
    WC    = 3'd2,
    PD    = 3'd3,
    CP    = 3'd4,
    ISSUE = 3'd5
  } state_t;

  localparam int unsigned BTN_SEL_A   = 3;
  localparam int unsigned BTN_SEL_B   = 2;
  localparam int unsigned BTN_CONFIRM = 1;
  localparam int unsigned BTN_CANCEL  = 0;

  localparam logic CMD_MOVE = 1'b0;
  localparam logic CMD_DROP = 1'b1;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CANCEL,
    ACT_CONFIRM,
    ACT_NEXT,
    ACT_PREV
  } act_t;

  // Only the highest-priority edge in a cycle is acted upon.
  function automatic act_t pick_action(input logic [3:0] rise);
    act_t a;
    a = ACT_NONE;
    if (rise[BTN_CANCEL])       a = ACT_CANCEL;
    else if (rise[BTN_CONFIRM]) a = ACT_CONFIRM;
    else if (rise[BTN_SEL_A])   a = ACT_NEXT;
    else if (rise[BTN_SEL_B])   a = ACT_PREV;
    return a;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector; the all-ones reset keeps buttons held through reset silent.
module btn_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '1;
    else     prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/turn_input_fsm.sv
// Turns four player buttons into a move or drop command for the rules engine.
module turn_input_fsm
  import turn_pkg::*;
#(
  parameter int N_PIECE     = 8,
  parameter int N_CAPT      = 7,
  parameter int N_DIR       = 8,
  parameter int N_CELL      = 81,
  parameter int TIMEOUT_CYC = 0,
  localparam int IW = $clog2(N_PIECE > N_CAPT ? N_PIECE : N_CAPT),
  localparam int AW = $clog2(N_DIR > N_CELL ? N_DIR : N_CELL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        btn,
  input  logic [N_CAPT-1:0] capt_avail,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_kind,
  output logic [IW-1:0]     cmd_idx,
  output logic [AW-1:0]     cmd_arg,
  output logic              player,
  output logic [2:0]        state,
  output logic              timeout
);

  localparam int unsigned NC = N_CAPT;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [IW-1:0] PIECE_MAX = IW'(N_PIECE - 1);
  localparam logic [AW-1:0] DIR_MAX   = AW'(N_DIR - 1);
  localparam logic [AW-1:0] CELL_MAX  = AW'(N_CELL - 1);

  state_t          st, st_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [AW-1:0]   arg_q, arg_n;
  logic            kind_q, kind_n;
  logic            ply_q, ply_n;
  logic            valid_q;
  logic            tmo_q;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [3:0]      rise;
  act_t            act;
  logic            acted;
  logic            fire;
  logic            timed;
  logic [N_CAPT-1:0] cur_bit;

  btn_edge #(.W(4)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .rise (rise)
  );

  // Cyclic search for the next (fwd) or previous set bit, excluding cur itself.
  function automatic logic [IW-1:0] capt_step(input logic [N_CAPT-1:0] avail,
                                              input logic [IW-1:0] cur,
                                              input logic fwd);
    logic [IW-1:0]     res;
    logic              found;
    int unsigned       pos;
    logic [N_CAPT-1:0] sh;
    res   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k < NC; k++) begin
      if (fwd) pos = (32'(cur) + k) % NC;
      else     pos = (32'(cur) + NC - k) % NC;
      sh = avail >> pos;
      if (!found && sh[0]) begin
        res   = IW'(pos);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] capt_lowest(input logic [N_CAPT-1:0] avail);
    logic [IW-1:0] res;
    res = '0;
    for (int unsigned k = NC; k > 0; k--) begin
      if (avail[k-1]) res = IW'(k - 1);
    end
    return res;
  endfunction

  assign act     = pick_action(rise);
  assign timed   = (st == WP) || (st == WC) || (st == PD) || (st == CP);
  assign cur_bit = capt_avail >> idx_q;

  always_comb begin
    st_n   = st;
    idx_n  = idx_q;
    arg_n  = arg_q;
    kind_n = kind_q;
    ply_n  = ply_q;
    acted  = 1'b0;
    fire   = 1'b0;
    case (st)
      POC: begin
        if (act == ACT_NEXT) begin
          st_n  = WP;
          idx_n = '0;
        end else if (act == ACT_PREV && |capt_avail) begin
          st_n  = WC;
          idx_n = capt_lowest(capt_avail);
        end
      end
      WP: begin
        acted = (act != ACT_NONE);
        case (act)
          ACT_NEXT:    idx_n = (idx_q == PIECE_MAX) ? '0 : idx_q + 1'b1;
          ACT_PREV:    idx_n = (idx_q == '0) ? PIECE_MAX : idx_q - 1'b1;
          ACT_CONFIRM: begin st_n = PD; arg_n = '0; end
          ACT_CANCEL:  st_n = POC;
          default: ;
        endcase
      end
      WC: begin
        acted = (act != ACT_NONE);
        case (act)
          ACT_NEXT: idx_n = capt_step(capt_avail, idx_q, 1'b1);
          ACT_PREV: idx_n = capt_step(capt_avail, idx_q, 1'b0);
          ACT_CONFIRM: begin
            if (cur_bit[0]) begin
              st_n  = CP;
              arg_n = '0;
            end else begin
              acted = 1'b0;
            end
          end
          ACT_CANCEL: st_n = POC;
          default: ;
        endcase
      end
      PD: begin
        acted = (act != ACT_NONE);
        case (act)
          ACT_NEXT:    arg_n = (arg_q == DIR_MAX) ? '0 : arg_q + 1'b1;
          ACT_PREV:    arg_n = (arg_q == '0) ? DIR_MAX : arg_q - 1'b1;
          ACT_CONFIRM: begin st_n = ISSUE; kind_n = CMD_MOVE; end
          ACT_CANCEL:  st_n = WP;
          default: ;
        endcase
      end
      CP: begin
        acted = (act != ACT_NONE);
        case (act)
          ACT_NEXT:    arg_n = (arg_q == CELL_MAX) ? '0 : arg_q + 1'b1;
          ACT_PREV:    arg_n = (arg_q == '0) ? CELL_MAX : arg_q - 1'b1;
          ACT_CONFIRM: begin st_n = ISSUE; kind_n = CMD_DROP; end
          ACT_CANCEL:  st_n = WC;
          default: ;
        endcase
      end
      ISSUE: begin
        if (valid_q && cmd_ready) begin
          st_n  = POC;
          ply_n = ~ply_q;
          idx_n = '0;
          arg_n = '0;
        end
      end
      default: st_n = POC;
    endcase

    if (TIMEOUT_CYC != 0 && timed && !acted && cnt_q == TO_LAST) begin
      fire = 1'b1;
      st_n = POC;
    end

    if (st_n != st || acted)                cnt_n = '0;
    else if (timed && TIMEOUT_CYC != 0)     cnt_n = cnt_q + 1'b1;
    else                                    cnt_n = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= POC;
      idx_q   <= '0;
      arg_q   <= '0;
      kind_q  <= CMD_MOVE;
      ply_q   <= 1'b0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st      <= st_n;
      idx_q   <= idx_n;
      arg_q   <= arg_n;
      kind_q  <= kind_n;
      ply_q   <= ply_n;
      valid_q <= (st_n == ISSUE);
      tmo_q   <= fire;
      cnt_q   <= cnt_n;
    end
  end

  assign state     = st;
  assign cmd_idx   = idx_q;
  assign cmd_arg   = arg_q;
  assign cmd_kind  = kind_q;
  assign player    = ply_q;
  assign cmd_valid = valid_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_turn_input_fsm.sv
// Directed bench for turn_input_fsm: vector table plus multi-cycle corner sequences.
module tb_turn_input_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [6:0] capt_avail;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_kind;
  logic [2:0] cmd_idx;
  logic [6:0] cmd_arg;
  logic       player;
  logic [2:0] state;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_input_fsm #(
    .N_PIECE     (8),
    .N_CAPT      (7),
    .N_DIR       (8),
    .N_CELL      (81),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .capt_avail (capt_avail),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_idx    (cmd_idx),
    .cmd_arg    (cmd_arg),
    .player     (player),
    .state      (state),
    .timeout    (timeout)
  );

  typedef struct {
    logic [3:0] b;
    logic [6:0] capt;
    logic       rdy;
    logic [2:0] st;
    logic [2:0] idx;
    logic [6:0] arg;
    logic       kind;
    logic       ply;
    logic       chk_ia;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] b, input logic [6:0] capt, input logic rdy,
                              input logic [2:0] st, input logic [2:0] idx, input logic [6:0] arg,
                              input logic kind, input logic ply, input logic chk_ia);
    vec_t v;
    v.b = b; v.capt = capt; v.rdy = rdy; v.st = st; v.idx = idx; v.arg = arg;
    v.kind = kind; v.ply = ply; v.chk_ia = chk_ia;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      btn        = vecs[i].b;
      capt_avail = vecs[i].capt;
      cmd_ready  = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d_valid", i), 32'(cmd_valid), 32'(vecs[i].st == 3'd5));
      chk($sformatf("v%0d_player", i), 32'(player), 32'(vecs[i].ply));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(0));
      if (vecs[i].chk_ia) begin
        chk($sformatf("v%0d_idx", i), 32'(cmd_idx), 32'(vecs[i].idx));
        chk($sformatf("v%0d_arg", i), 32'(cmd_arg), 32'(vecs[i].arg));
      end
      if (vecs[i].st == 3'd5)
        chk($sformatf("v%0d_kind", i), 32'(cmd_kind), 32'(vecs[i].kind));
      btn       = 4'b0000;
      cmd_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    @(negedge clk);
    btn = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    btn        = 4'b0000;
    capt_avail = 7'b0;
    cmd_ready  = 1'b0;

    // Move flow: 0..6
    vecs.push_back(mk(4'h8, 7'h00, 1'b0, 3'd1, 3'd0, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h8, 7'h00, 1'b0, 3'd1, 3'd1, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h8, 7'h00, 1'b0, 3'd1, 3'd2, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h8, 7'h00, 1'b0, 3'd1, 3'd3, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h2, 7'h00, 1'b0, 3'd3, 3'd3, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h4, 7'h00, 1'b0, 3'd3, 3'd3, 7'd7,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h2, 7'h00, 1'b0, 3'd5, 3'd3, 7'd7,  1'b0, 1'b0, 1'b1));
    // Drop flow and handshake: 7..14
    vecs.push_back(mk(4'h4, 7'h14, 1'b0, 3'd2, 3'd2, 7'd0,  1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(4'h8, 7'h14, 1'b0, 3'd2, 3'd4, 7'd0,  1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(4'h8, 7'h14, 1'b0, 3'd2, 3'd2, 7'd0,  1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(4'h2, 7'h14, 1'b0, 3'd4, 3'd2, 7'd0,  1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(4'h4, 7'h14, 1'b0, 3'd4, 3'd2, 7'd80, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(4'h4, 7'h14, 1'b0, 3'd4, 3'd2, 7'd79, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(4'h2, 7'h14, 1'b0, 3'd5, 3'd2, 7'd79, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(4'h0, 7'h14, 1'b1, 3'd0, 3'd0, 7'd0,  1'b0, 1'b0, 1'b1));
    // Guards: 15..18
    vecs.push_back(mk(4'h4, 7'h00, 1'b0, 3'd0, 3'd0, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h4, 7'h04, 1'b0, 3'd2, 3'd2, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h2, 7'h00, 1'b0, 3'd2, 3'd2, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h1, 7'h00, 1'b0, 3'd0, 3'd0, 7'd0,  1'b0, 1'b0, 1'b0));
    // Wrap, priority and back: 19..25
    vecs.push_back(mk(4'h8, 7'h00, 1'b0, 3'd1, 3'd0, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h4, 7'h00, 1'b0, 3'd1, 3'd7, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h2, 7'h00, 1'b0, 3'd3, 3'd7, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h3, 7'h00, 1'b0, 3'd1, 3'd7, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h2, 7'h00, 1'b0, 3'd3, 3'd7, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h1, 7'h00, 1'b0, 3'd1, 3'd7, 7'd0,  1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'h1, 7'h00, 1'b0, 3'd0, 3'd0, 7'd0,  1'b0, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state",   32'(state),     32'(0));
    chk("rst_idx",     32'(cmd_idx),   32'(0));
    chk("rst_arg",     32'(cmd_arg),   32'(0));
    chk("rst_player",  32'(player),    32'(0));
    chk("rst_valid",   32'(cmd_valid), 32'(0));
    chk("rst_timeout", 32'(timeout),   32'(0));

    run_vecs(0, 6);

    // ISSUE held with ready low; a SEL_A edge in the middle must be ignored.
    for (int i = 0; i < 5; i++) begin
      btn = (i == 2) ? 4'h8 : 4'h0;
      @(negedge clk);
      chk($sformatf("hold%0d_state", i), 32'(state),     32'(5));
      chk($sformatf("hold%0d_valid", i), 32'(cmd_valid), 32'(1));
      chk($sformatf("hold%0d_idx", i),   32'(cmd_idx),   32'(3));
      chk($sformatf("hold%0d_arg", i),   32'(cmd_arg),   32'(7));
      chk($sformatf("hold%0d_kind", i),  32'(cmd_kind),  32'(0));
    end
    btn       = 4'h0;
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("hs_state",  32'(state),     32'(0));
    chk("hs_valid",  32'(cmd_valid), 32'(0));
    chk("hs_player", 32'(player),    32'(1));
    chk("hs_idx",    32'(cmd_idx),   32'(0));
    @(negedge clk);
    chk("hs_single", 32'(state),     32'(0));

    run_vecs(7, 25);

    // Button held across reset release must not fire until re-pressed.
    btn = 4'h8;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("held%0d_state", i), 32'(state), 32'(0));
    end
    btn = 4'h0;
    @(negedge clk);
    btn = 4'h8;
    @(negedge clk);
    chk("repress_state", 32'(state), 32'(1));
    btn = 4'h0;
    @(negedge clk);
    press(4'h1);
    chk("cancel_poc", 32'(state), 32'(0));

    // Timeout: enter CP, then stay idle.
    capt_avail = 7'h04;
    press(4'h4);
    chk("to_wc", 32'(state), 32'(2));
    btn = 4'h2;
    @(negedge clk);
    btn = 4'h0;
    chk("to_cp", 32'(state), 32'(4));
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk($sformatf("to_idle%0d_state", i), 32'(state),   32'(4));
      chk($sformatf("to_idle%0d_pulse", i), 32'(timeout), 32'(0));
    end
    @(negedge clk);
    chk("to_fire_state",  32'(state),   32'(0));
    chk("to_fire_pulse",  32'(timeout), 32'(1));
    chk("to_fire_player", 32'(player),  32'(0));
    @(negedge clk);
    chk("to_pulse_end",   32'(timeout), 32'(0));
    chk("to_stay_poc",    32'(state),   32'(0));

    // Reset during ISSUE discards the command immediately.
    press(4'h8);
    press(4'h2);
    press(4'h2);
    chk("ri_state", 32'(state),     32'(5));
    chk("ri_valid", 32'(cmd_valid), 32'(1));
    rst = 1'b1;
    #1;
    chk("ri_valid_clr", 32'(cmd_valid), 32'(0));
    chk("ri_state_clr", 32'(state),     32'(0));
    chk("ri_idx_clr",   32'(cmd_idx),   32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ri_after", 32'(cmd_valid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
